// File: rtl/tp_lut_pkg.sv
// Shared definitions for the track-parameter lookup loader.
// Default widths match the lookup memory instance.
package tp_lut_pkg;

    localparam int RAM_WIDTH_DEF     = 18;
    localparam int RAM_ADDR_BITS_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // Sum of 2**a words of w bits never overflows w+a bits.
    function automatic int csum_w(input int w, input int a);
        return w + a;
    endfunction

endpackage

// File: rtl/tp_lut_csum.sv
// Clearable, enabled, zero-extending accumulator.
// One instance sums written words, the other sums read-back words.
module tp_lut_csum
    import tp_lut_pkg::*;
#(
    parameter int IN_W  = RAM_WIDTH_DEF,
    parameter int OUT_W = csum_w(RAM_WIDTH_DEF, RAM_ADDR_BITS_DEF)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             EN,
    input  logic [IN_W-1:0]  DIN,
    output logic [OUT_W-1:0] SUM
);

    logic [OUT_W-1:0] din_ext;

    assign din_ext = {{(OUT_W-IN_W){1'b0}}, DIN};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            SUM <= '0;
        end else if (CLR) begin
            SUM <= '0;
        end else if (EN) begin
            SUM <= SUM + din_ext;
        end
    end

endmodule

// File: rtl/tp_lut_loader.sv
// Stream-to-lookup-memory loader with optional read-back checksum pass.
// Fills every table entry in order, then optionally re-reads and compares sums.
module tp_lut_loader
    import tp_lut_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter bit VERIFY        = 1'b1,
    localparam int CSUM_W       = csum_w(RAM_WIDTH, RAM_ADDR_BITS)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [RAM_WIDTH-1:0]     S_DATA,
    input  logic                     S_VALID,
    output logic                     S_READY,
    output logic                     LUT_WR_EN,
    output logic [RAM_ADDR_BITS-1:0] LUT_WRITE_A,
    output logic [RAM_WIDTH-1:0]     LUT_DI,
    output logic                     LUT_RD_EN,
    output logic [RAM_ADDR_BITS-1:0] LUT_READ_A,
    input  logic [RAM_WIDTH-1:0]     LUT_DO,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERROR,
    output logic [CSUM_W-1:0]        CHECKSUM
);

    localparam int DEPTH = 2**RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS-1:0] LAST_A =
        RAM_ADDR_BITS'(DEPTH-1);
    localparam logic [RAM_ADDR_BITS:0] VER_END =
        (RAM_ADDR_BITS+1)'(DEPTH+1);

    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [RAM_ADDR_BITS:0]   vcnt;
    logic                     rd_v;
    logic                     beat;
    logic                     restart;
    logic [CSUM_W-1:0]        rd_csum;

    assign S_READY = (state == ST_LOAD);
    assign beat    = S_VALID & S_READY;
    assign BUSY    = (state == ST_LOAD) || (state == ST_DRAIN) ||
                     (state == ST_VERIFY);
    assign restart = START && ((state == ST_IDLE) ||
                     (state == ST_DONE) || (state == ST_ERR));

    tp_lut_csum #(.IN_W(RAM_WIDTH), .OUT_W(CSUM_W)) u_wr_csum (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (restart),
        .EN    (beat),
        .DIN   (S_DATA),
        .SUM   (CHECKSUM)
    );

    // Read data is accumulated once rd_v marks DO as holding a real read.
    tp_lut_csum #(.IN_W(RAM_WIDTH), .OUT_W(CSUM_W)) u_rd_csum (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (restart),
        .EN    (rd_v),
        .DIN   (LUT_DO),
        .SUM   (rd_csum)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            wr_addr     <= '0;
            vcnt        <= '0;
            rd_v        <= 1'b0;
            LUT_WR_EN   <= 1'b0;
            LUT_WRITE_A <= '0;
            LUT_DI      <= '0;
            LUT_RD_EN   <= 1'b0;
            LUT_READ_A  <= '0;
            DONE        <= 1'b0;
            ERROR       <= 1'b0;
        end else begin
            LUT_WR_EN <= beat;
            rd_v      <= LUT_RD_EN;
            if (beat) begin
                LUT_WRITE_A <= wr_addr;
                LUT_DI      <= S_DATA;
                wr_addr     <= wr_addr + 1'b1;
            end
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (START) begin
                        state   <= ST_LOAD;
                        wr_addr <= '0;
                        DONE    <= 1'b0;
                        ERROR   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat && (wr_addr == LAST_A)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (VERIFY) begin
                        state      <= ST_VERIFY;
                        LUT_RD_EN  <= 1'b1;
                        LUT_READ_A <= '0;
                        vcnt       <= '0;
                    end else begin
                        state <= ST_DONE;
                        DONE  <= 1'b1;
                    end
                end
                ST_VERIFY: begin
                    vcnt <= vcnt + 1'b1;
                    if (LUT_READ_A == LAST_A) begin
                        LUT_RD_EN <= 1'b0;
                    end else begin
                        LUT_READ_A <= LUT_READ_A + 1'b1;
                    end
                    // Last read has landed in rd_csum by this point.
                    if (vcnt == VER_END) begin
                        if (rd_csum == CHECKSUM) begin
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            ERROR <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tp_lut_loader.sv
// Scoreboard bench for tp_lut_loader with a behavioural lookup memory.
// Second instance covers the no-verify build.
module tb_tp_lut_loader;

    localparam int W  = 18;
    localparam int A  = 5;
    localparam int D  = 32;
    localparam int CW = W + A;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [W-1:0]  S_DATA = '0;
    logic          S_VALID = 1'b0;
    logic          S_READY;
    logic          LUT_WR_EN;
    logic [A-1:0]  LUT_WRITE_A;
    logic [W-1:0]  LUT_DI;
    logic          LUT_RD_EN;
    logic [A-1:0]  LUT_READ_A;
    logic [W-1:0]  LUT_DO = '0;
    logic          BUSY, DONE, ERROR;
    logic [CW-1:0] CHECKSUM;

    logic          nv_START = 1'b0;
    logic [W-1:0]  nv_S_DATA = '0;
    logic          nv_S_VALID = 1'b0;
    logic          nv_S_READY;
    logic          nv_LUT_WR_EN;
    logic [A-1:0]  nv_LUT_WRITE_A;
    logic [W-1:0]  nv_LUT_DI;
    logic          nv_LUT_RD_EN;
    logic [A-1:0]  nv_LUT_READ_A;
    logic [W-1:0]  nv_LUT_DO = '0;
    logic          nv_BUSY, nv_DONE, nv_ERROR;
    logic [CW-1:0] nv_CHECKSUM;

    tp_lut_loader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .VERIFY(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .LUT_WR_EN(LUT_WR_EN), .LUT_WRITE_A(LUT_WRITE_A),
        .LUT_DI(LUT_DI), .LUT_RD_EN(LUT_RD_EN),
        .LUT_READ_A(LUT_READ_A), .LUT_DO(LUT_DO),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .CHECKSUM(CHECKSUM)
    );

    tp_lut_loader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .VERIFY(1'b0)) dut_nv (
        .CLK(CLK), .RST_N(RST_N), .START(nv_START),
        .S_DATA(nv_S_DATA), .S_VALID(nv_S_VALID), .S_READY(nv_S_READY),
        .LUT_WR_EN(nv_LUT_WR_EN), .LUT_WRITE_A(nv_LUT_WRITE_A),
        .LUT_DI(nv_LUT_DI), .LUT_RD_EN(nv_LUT_RD_EN),
        .LUT_READ_A(nv_LUT_READ_A), .LUT_DO(nv_LUT_DO),
        .BUSY(nv_BUSY), .DONE(nv_DONE), .ERROR(nv_ERROR),
        .CHECKSUM(nv_CHECKSUM)
    );

    always #5 CLK = ~CLK;

    // Read-first lookup memory; corrupt lets the bench overwrite a word.
    logic [W-1:0] mem [D];
    logic         corrupt = 1'b0;
    logic [A-1:0] corrupt_a = '0;

    always @(posedge CLK) begin
        if (LUT_WR_EN === 1'b1) mem[LUT_WRITE_A] <= LUT_DI;
        if (corrupt) mem[corrupt_a] <= 18'h1;
        if (LUT_RD_EN === 1'b1) LUT_DO <= mem[LUT_READ_A];
    end

    typedef struct packed {
        logic [A-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    logic [W-1:0] model [D];
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           wsum = 0;
    int           waddr = 0;
    int           start_cyc = 0;
    int           last_beat_cyc = 0;
    int           nv_rd_seen = 0;
    int           nv_wr_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    endfunction

    // Monitor: every memory write must match the next accepted beat.
    always @(negedge CLK) begin
        wr_t e;
        if (LUT_WR_EN === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_write: actual addr=%0d data=0x%0h required no write",
                         LUT_WRITE_A, LUT_DI);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(LUT_WRITE_A), 64'(e.a));
                chk("wr_data", 64'(LUT_DI), 64'(e.d));
            end
        end
        if (nv_LUT_RD_EN === 1'b1) nv_rd_seen++;
        if (nv_LUT_WR_EN === 1'b1) nv_wr_cnt++;
    end

    task automatic new_load();
        wsum = 0;
        waddr = 0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) nv_START = 1'b1;
        else START = 1'b1;
        start_cyc = cyc;
        @(negedge CLK);
        nv_START = 1'b0;
        START = 1'b0;
    endtask

    // dmode: 0 = data equals index, 1 = fixed value, 2 = random
    task automatic stream(input bit sel, input int n, input bit toggle,
                          input int dmode, input logic [W-1:0] fval,
                          input int start_at, input bit hold);
        int got = 0;
        int it = 0;
        logic [W-1:0] d;
        logic v;
        logic rdy;
        wr_t e;
        while (got < n && it < 400) begin
            unique case (dmode)
                0: d = W'(got);
                1: d = fval;
                default: begin
                    d = W'($urandom);
                    if (d == 1) d = 2;
                end
            endcase
            v = toggle ? ((it % 2) == 0) : 1'b1;
            if (!sel) START = (it == start_at);
            if (sel) begin
                nv_S_VALID = v;
                nv_S_DATA = d;
                rdy = nv_S_READY;
            end else begin
                S_VALID = v;
                S_DATA = d;
                rdy = S_READY;
            end
            if (v && rdy) begin
                if (!sel) begin
                    e.a = A'(waddr);
                    e.d = d;
                    exp_q.push_back(e);
                    model[waddr] = d;
                end
                wsum += int'(d);
                waddr++;
                got++;
                last_beat_cyc = cyc;
            end
            it++;
            @(negedge CLK);
        end
        START = 1'b0;
        if (sel) nv_S_VALID = hold;
        else S_VALID = hold;
        chk("stream_beats", 64'(got), 64'(n));
    endtask

    task automatic wait_end(input bit sel, input int budget, output int at);
        int k = 0;
        while (!(sel ? (nv_DONE | nv_ERROR) : (DONE | ERROR)) &&
               k < budget) begin
            @(negedge CLK);
            k++;
        end
        at = cyc;
        chk("wait_end_in_budget", 64'(k < budget), 64'(1));
    endtask

    function automatic int model_sum();
        int s = 0;
        for (int i = 0; i < D; i++) s += int'(model[i]);
        return s;
    endfunction

    initial begin
        int at;
        bit exp_err;
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int at;
        bit exp_err;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_outputs",
            64'({S_READY, LUT_WR_EN, LUT_WRITE_A, LUT_DI, LUT_RD_EN,
                 LUT_READ_A, BUSY, DONE, ERROR, CHECKSUM}), 64'(0));
        chk("reset_outputs_nv",
            64'({nv_S_READY, nv_LUT_WR_EN, nv_LUT_RD_EN, nv_BUSY,
                 nv_DONE, nv_ERROR, nv_CHECKSUM}), 64'(0));
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_not_ready", 64'(S_READY), 64'(0));

        // Test 1: counting pattern at full rate, latency to DONE
        new_load();
        pulse_start(1'b0);
        stream(1'b0, D, 1'b0, 0, '0, -1, 1'b0);
        wait_end(1'b0, 200, at);
        chk("t1_latency", 64'(at - start_cyc), 64'(2*D + 4));
        chk("t1_checksum", 64'(CHECKSUM), 64'h1F0);
        chk("t1_done", 64'({DONE, ERROR}), 64'b10);
        for (int i = 0; i < D; i++) chk("t1_mem", 64'(mem[i]), 64'(model[i]));
        chk("t1_queue_empty", 64'(exp_q.size()), 64'(0));

        // Test 2: S_VALID toggling, all-ones data
        new_load();
        pulse_start(1'b0);
        stream(1'b0, D, 1'b1, 1, 18'h3FFFF, -1, 1'b0);
        wait_end(1'b0, 200, at);
        chk("t2_checksum", 64'(CHECKSUM), 64'h7FFFE0);
        chk("t2_checksum_model", 64'(CHECKSUM), 64'(wsum));
        chk("t2_done", 64'({DONE, ERROR}), 64'b10);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));

        // Test 3: corrupt one word before it is read back
        new_load();
        pulse_start(1'b0);
        stream(1'b0, D, 1'b0, 2, '0, -1, 1'b0);
        begin
            int k = 0;
            while (LUT_RD_EN !== 1'b1 && k < 10) begin
                @(negedge CLK);
                k++;
            end
        end
        corrupt_a = 5'd20;
        corrupt = 1'b1;
        model[20] = 18'h1;
        @(negedge CLK);
        corrupt = 1'b0;
        exp_err = (model_sum() != wsum);
        wait_end(1'b0, 200, at);
        chk("t3_error", 64'(ERROR), 64'(exp_err));
        chk("t3_done", 64'(DONE), 64'(!exp_err));
        chk("t3_checksum", 64'(CHECKSUM), 64'(wsum));

        // Test 4: START clears ERROR, then reset after 10 beats
        new_load();
        pulse_start(1'b0);
        chk("t3_start_clears", 64'({ERROR, BUSY}), 64'b01);
        stream(1'b0, 10, 1'b0, 2, '0, -1, 1'b0);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("t4_reset_outputs",
            64'({S_READY, LUT_WR_EN, LUT_WRITE_A, LUT_DI, LUT_RD_EN,
                 LUT_READ_A, BUSY, DONE, ERROR, CHECKSUM}), 64'(0));
        for (int i = 0; i < 10; i++) chk("t4_mem_kept", 64'(mem[i]), 64'(model[i]));
        chk("t4_queue_empty", 64'(exp_q.size()), 64'(0));

        // Test 5: START during LOAD/VERIFY ignored, extra S_VALID ignored
        new_load();
        pulse_start(1'b0);
        stream(1'b0, D, 1'b0, 2, '0, 6, 1'b1);
        chk("t5_ready_drop", 64'(S_READY), 64'(0));
        repeat (5) @(negedge CLK);
        chk("t5_in_verify", 64'(LUT_RD_EN), 64'(1));
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("t5_busy_kept", 64'(BUSY), 64'(1));
        wait_end(1'b0, 200, at);
        S_VALID = 1'b0;
        chk("t5_done", 64'({DONE, ERROR}), 64'b10);
        chk("t5_checksum", 64'(CHECKSUM), 64'(wsum));
        repeat (3) @(negedge CLK);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'(0));

        // Test 6: no-verify build
        new_load();
        pulse_start(1'b1);
        stream(1'b1, D, 1'b0, 2, '0, -1, 1'b0);
        wait_end(1'b1, 50, at);
        chk("t6_done_delay", 64'(at - last_beat_cyc), 64'(2));
        chk("t6_done", 64'({nv_DONE, nv_ERROR}), 64'b10);
        chk("t6_no_reads", 64'(nv_rd_seen), 64'(0));
        chk("t6_writes", 64'(nv_wr_cnt), 64'(D));
        chk("t6_checksum", 64'(nv_CHECKSUM), 64'(wsum));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
